// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, parity selections and baud arithmetic.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   // Clocks per bit, integer division (truncates).
   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
// restart reloads RESTART_VAL, so a receiver can start at a half-bit offset.
module uart_tx_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned RESTART_VAL  = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic bit_done
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] StartCnt = CntW'(RESTART_VAL);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Free-running wrap counter with synchronous restart.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = StartCnt;
      end else if (cnt_q == LastCnt) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_done = (cnt_q == LastCnt);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register, LSB-first framing with optional parity and
// one or two stop bits, CTS# sampled at each frame start.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 12_000_000,
   parameter int unsigned BAUD      = 115_200,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_data_ready,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx,
   input  logic       cts_n
);

   localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD);
   localparam logic [2:0]  LastStop   = 3'(STOP_BITS - 1);

   uart_state_e state_q, state_d;
   logic [7:0]  holding_q, holding_d;
   logic        holding_full_q, holding_full_d;
   logic [7:0]  shift_q, shift_d;
   logic        parity_q, parity_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        cts_meta_q, cts_s_q;
   logic        accept, start_frame, baud_restart, bit_done;

   assign accept = tx_data_ready & ~holding_full_q;

   uart_tx_baud_gen #(
      .CLKS_PER_BIT (ClksPerBit),
      .RESTART_VAL  (0)
   ) u_baud (
      .clk      (clk),
      .reset    (reset),
      .restart  (baud_restart),
      .bit_done (bit_done)
   );

   // CTS# synchroniser; resets to "not clear".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cts_meta_q <= 1'b1;
         cts_s_q    <= 1'b1;
      end else begin
         cts_meta_q <= cts_n;
         cts_s_q    <= cts_meta_q;
      end
   end

   // Next-state: holding register load, frame sequencing and line level.
   always_comb begin
      state_d        = state_q;
      holding_d      = holding_q;
      holding_full_d = holding_full_q;
      shift_d        = shift_q;
      parity_d       = parity_q;
      bit_cnt_d      = bit_cnt_q;
      tx_d           = tx_q;
      start_frame    = 1'b0;
      baud_restart   = 1'b0;

      if (accept) begin
         holding_d      = tx_data;
         holding_full_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (holding_full_q && !cts_s_q) start_frame = 1'b1;
         end
         StStart: begin
            if (bit_done) begin
               state_d   = StData;
               tx_d      = shift_q[0];
               bit_cnt_d = '0;
            end
         end
         StData: begin
            if (bit_done) begin
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = '0;
                  if (PARITY != PARITY_NONE) begin
                     state_d = StParity;
                     tx_d    = parity_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         StParity: begin
            if (bit_done) begin
               state_d   = StStop;
               tx_d      = 1'b1;
               bit_cnt_d = '0;
            end
         end
         StStop: begin
            if (bit_done) begin
               if (bit_cnt_q == LastStop) begin
                  // Chain straight into the next frame when a byte is waiting.
                  if (holding_full_q && !cts_s_q) begin
                     start_frame = 1'b1;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase

      // accept needs holding empty, start_frame needs it full: never both.
      if (start_frame) begin
         state_d        = StStart;
         shift_d        = holding_q;
         parity_d       = (PARITY == PARITY_ODD) ? ~(^holding_q) : (^holding_q);
         holding_full_d = 1'b0;
         tx_d           = 1'b0;
         baud_restart   = 1'b1;
      end

      busy_d = holding_full_d | (state_d != StIdle);
   end

   // State register; reset forces the line idle and discards any byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         holding_q      <= '0;
         holding_full_q <= 1'b0;
         shift_q        <= '0;
         parity_q       <= 1'b0;
         bit_cnt_q      <= '0;
         tx_q           <= 1'b1;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         holding_q      <= holding_d;
         holding_full_q <= holding_full_d;
         shift_q        <= shift_d;
         parity_q       <= parity_d;
         bit_cnt_q      <= bit_cnt_d;
         tx_q           <= tx_d;
         busy_q         <= busy_d;
      end
   end

   assign tx_ready = ~holding_full_q;
   assign tx_busy  = busy_q;
   assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E1, 8O2) at 10 clocks per bit, frames
// compared against an expected bit list built from the framing rules.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int Cpb = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cts_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       stb = 1'b0;
   int         sel = 0;

   logic stb0, stb1, stb2;
   logic rdy0, rdy1, rdy2, busy0, busy1, busy2, tx0, tx1, tx2;
   logic rdy_s, busy_s, tx_s;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   assign stb0 = stb && (sel == 0);
   assign stb1 = stb && (sel == 1);
   assign stb2 = stb && (sel == 2);

   always_comb begin
      rdy_s = rdy0; busy_s = busy0; tx_s = tx0;
      if (sel == 1) begin rdy_s = rdy1; busy_s = busy1; tx_s = tx1; end
      if (sel == 2) begin rdy_s = rdy2; busy_s = busy2; tx_s = tx2; end
   end

   uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_data_ready(stb0),
      .tx_ready(rdy0), .tx_busy(busy0), .tx(tx0), .cts_n(cts_n));
   uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_data_ready(stb1),
      .tx_ready(rdy1), .tx_busy(busy1), .tx(tx1), .cts_n(cts_n));
   uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_data_ready(stb2),
      .tx_ready(rdy2), .tx_busy(busy2), .tx(tx2), .cts_n(cts_n));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected line levels of one frame, one entry per bit period.
   task automatic build_frame(input logic [7:0] b, input int par, input int stops,
                              output logic bits [0:11], output int n);
      int ones;
      ones = $countones(b);
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = b[i];
      n = 9;
      if (par == 2) begin bits[n] = 1'((ones % 2) == 1); n++; end
      if (par == 1) begin bits[n] = 1'((ones % 2) == 0); n++; end
      for (int i = 0; i < stops; i++) begin bits[n] = 1'b1; n++; end
   endtask

   // Called in the first cycle of the start bit; returns just after the frame's last edge.
   task automatic check_frame(input logic [7:0] b, input int par, input int stops,
                              input string tag);
      logic bits [0:11];
      int   n;
      int   good;
      build_frame(b, par, stops, bits, n);
      for (int i = 0; i < n; i++) begin
         good = 0;
         for (int c = 0; c < Cpb; c++) begin
            if (tx_s === bits[i]) good++;
            tick();
         end
         chk($sformatf("%s bit%0d", tag, i), good, Cpb);
      end
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (rdy_s !== 1'b1 && k < 300) begin tick(); k++; end
      chk({tag, " ready"}, rdy_s, 1);
   endtask

   // Offer a byte to an idle transmitter with CTS asserted and check the whole frame.
   task automatic send_frame(input logic [7:0] b, input int par, input int stops,
                             input string tag);
      wait_ready(tag);
      tx_data = b;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      chk({tag, " ready low after accept"}, rdy_s, 0);
      chk({tag, " busy after accept"}, busy_s, 1);
      chk({tag, " line idle at accept"}, tx_s, 1);
      tick();
      chk({tag, " ready again"}, rdy_s, 1);
      check_frame(b, par, stops, tag);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " busy end"}, busy_s, 0);
      chk({tag, " tx end"}, tx_s, 1);
   endtask

   initial begin
      logic [7:0] b;
      int         k;
      int         good;

      // Reset state
      #1 reset = 1'b1;
      #2;
      chk("reset tx", tx0, 1);
      chk("reset ready", rdy0, 1);
      chk("reset busy", busy0, 0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();

      // 8N1 0x55
      sel = 0;
      send_frame(8'h55, 0, 1, "f55");
      check_idle("f55");

      // Back-to-back: second byte offered during the first start bit
      wait_ready("b2b");
      tx_data = 8'hA5;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      tick();
      chk("b2b ready in start", rdy_s, 1);
      tx_data = 8'h3C;
      stb = 1'b1;
      fork
         check_frame(8'hA5, 0, 1, "b2b A5");
         begin tick(); stb = 1'b0; end
      join
      check_frame(8'h3C, 0, 1, "b2b 3C");
      check_idle("b2b");

      // Randomised 8N1 bytes with random idle gaps
      for (int r = 0; r < 5; r++) begin
         b = 8'($urandom);
         repeat ($urandom_range(0, 3)) tick();
         send_frame(b, 0, 1, $sformatf("rnd%0d", r));
         check_idle($sformatf("rnd%0d", r));
      end

      // CTS held off: byte waits, extra strobe ignored
      cts_n = 1'b1;
      repeat (3) tick();
      wait_ready("cts");
      tx_data = 8'h81;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      good = 0;
      for (int c = 0; c < 20; c++) begin
         if (tx_s === 1'b1) good++;
         tick();
      end
      chk("cts line held idle", good, 20);
      chk("cts busy", busy_s, 1);
      chk("cts ready", rdy_s, 0);
      tx_data = 8'h22;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      tick();
      cts_n = 1'b0;
      k = 0;
      while (tx_s !== 1'b0 && k < 8) begin tick(); k++; end
      chk("cts start latency ok", 32'(k <= 3 && tx_s === 1'b0), 1);
      check_frame(8'h81, 0, 1, "cts 81");
      good = 0;
      for (int c = 0; c < 30; c++) begin
         if (tx_s === 1'b1 && busy_s === 1'b0) good++;
         tick();
      end
      chk("cts 22 never sent", good, 30);

      // Even parity, one stop bit
      sel = 1;
      send_frame(8'h07, 2, 1, "even07");
      check_idle("even07");
      for (int r = 0; r < 2; r++) begin
         b = 8'($urandom);
         send_frame(b, 2, 1, $sformatf("even_rnd%0d", r));
      end

      // Odd parity, two stop bits
      sel = 2;
      send_frame(8'h07, 1, 2, "odd07");
      check_idle("odd07");
      for (int r = 0; r < 2; r++) begin
         b = 8'($urandom);
         send_frame(b, 1, 2, $sformatf("odd_rnd%0d", r));
      end
      check_idle("odd_rnd");

      // Reset in the middle of data bit 3 of 0xF0
      sel = 0;
      wait_ready("rst");
      tx_data = 8'hF0;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      repeat (1 + 4 * Cpb + Cpb / 2) tick();
      chk("rst pre bit3", tx_s, 0);
      #2 reset = 1'b1;
      #1;
      chk("rst async tx", tx_s, 1);
      chk("rst async ready", rdy_s, 1);
      chk("rst async busy", busy_s, 0);
      repeat (2) tick();
      reset = 1'b0;
      good = 0;
      for (int c = 0; c < 15; c++) begin
         if (tx_s === 1'b1 && busy_s === 1'b0) good++;
         tick();
      end
      chk("rst no leftover frame", good, 15);
      send_frame(8'h0F, 0, 1, "post_rst 0F");
      check_idle("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global time limit
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_chk);
      $fatal(1, "timeout");
   end

endmodule
